gty_lane_bringup: RTL and testbench

Per-lane reset and bring-up sequencer for the GTY lanes of a QSGMII/10G quad. It sits between the quad PLL and lanes and the MAC wrappers. For each lane it:
- waits for a stable QPLL lock;
- sequences TX then RX resets;
- waits for comma alignment before declaring the lane up;
- retrains RX on alignment loss or an excessive symbol-error rate.

It replaces the free-running power-on reset counter.

---
 rtl/gty_bringup_pkg.sv | 31 +++
 rtl/gty_lane_bringup_if.sv | 30 +++
 rtl/gty_lane_bringup_fsm.sv | 147 ++++++++++++++
 rtl/gty_lane_bringup.sv | 76 +++++++
 tb/tb_gty_lane_bringup.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gty_bringup_pkg.sv
// Shared types and constants for the GTY lane bring-up sequencer.
package gty_bringup_pkg;

    // Per-lane sequencer state; the encoding is exposed on lane_state for
    // debug and register readback, so it must stay fixed.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_PLL = 3'd1,
        TX_RST   = 3'd2,
        TX_WAIT  = 3'd3,
        RX_RST   = 3'd4,
        RX_WAIT  = 3'd5,
        ALIGN    = 3'd6,
        UP       = 3'd7
    } lane_bringup_state_t;

    localparam int RETRAIN_MAX = 255;
    localparam int RETRAIN_W   = 8;

    // TX reset is held until the TX reset pulse itself has completed.
    function automatic logic tx_reset_of(lane_bringup_state_t s);
        return (s == IDLE) || (s == WAIT_PLL) || (s == TX_RST);
    endfunction

    // RX reset is held through the whole TX bring-up and the RX reset pulse.
    function automatic logic rx_reset_of(lane_bringup_state_t s);
        return (s == IDLE) || (s == WAIT_PLL) || (s == TX_RST) ||
               (s == TX_WAIT) || (s == RX_RST);
    endfunction

endpackage

// File: rtl/gty_lane_bringup_if.sv
// Signal bundle between the quad (PLL + GT lanes) and the bring-up sequencer.
// There is no valid/ready handshake here: every input is a level already
// synchronized to clk, except rx_err which is a one-cycle pulse per error
// event; every output is a registered level. slave is the sequencer side,
// master is the side that owns the GT status and consumes the resets.
interface gty_lane_bringup_if #(
    parameter int NUM_LANES = 3
);
    logic                   qpll_lock;
    logic [NUM_LANES-1:0]   lane_enable;
    logic [NUM_LANES-1:0]   tx_reset_done;
    logic [NUM_LANES-1:0]   rx_reset_done;
    logic [NUM_LANES-1:0]   rx_aligned;
    logic [NUM_LANES-1:0]   rx_err;
    logic [NUM_LANES-1:0]   tx_reset;
    logic [NUM_LANES-1:0]   rx_reset;
    logic [NUM_LANES-1:0]   lane_up;
    logic [8*NUM_LANES-1:0] retrain_count;
    logic [3*NUM_LANES-1:0] lane_state;

    modport master (
        output qpll_lock, lane_enable, tx_reset_done, rx_reset_done, rx_aligned, rx_err,
        input  tx_reset, rx_reset, lane_up, retrain_count, lane_state
    );

    modport slave (
        input  qpll_lock, lane_enable, tx_reset_done, rx_reset_done, rx_aligned, rx_err,
        output tx_reset, rx_reset, lane_up, retrain_count, lane_state
    );
endinterface

// File: rtl/gty_lane_bringup_fsm.sv
// One lane's bring-up sequencer: state machine, hold/timeout timer,
// RX error-rate monitor and saturating retrain counter.
module gty_lane_bringup_fsm
    import gty_bringup_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES = 64,
    parameter int DONE_TIMEOUT      = 65535,
    parameter int ERR_WINDOW        = 4096,
    parameter int ERR_THRESHOLD     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_stable,
    input  logic                 lane_enable,
    input  logic                 tx_reset_done,
    input  logic                 rx_reset_done,
    input  logic                 rx_aligned,
    input  logic                 rx_err,
    output logic                 tx_reset,
    output logic                 rx_reset,
    output logic                 lane_up,
    output logic [RETRAIN_W-1:0] retrain_count,
    output lane_bringup_state_t  state
);
    // One timer serves both reset-hold and done/align timeouts, so it is
    // sized for the larger of the two limits.
    localparam int TMR_MAX = (RESET_HOLD_CYCLES > DONE_TIMEOUT) ? RESET_HOLD_CYCLES : DONE_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int WIN_W   = $clog2(ERR_WINDOW + 1);
    localparam int ERR_W   = $clog2(ERR_THRESHOLD + 1);

    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(ERR_WINDOW - 1);
    localparam logic [ERR_W-1:0] ERR_LIMIT = ERR_W'(ERR_THRESHOLD);

    logic [TMR_W-1:0]    timer;
    logic [WIN_W-1:0]    win_cnt;
    logic [ERR_W-1:0]    err_cnt;
    logic [ERR_W-1:0]    err_base;
    logic [ERR_W-1:0]    err_nxt;
    logic                hold_last;
    logic                wait_last;
    logic                win_wrap;
    logic                retry;
    lane_bringup_state_t state_nxt;

    // Error-window bookkeeping: a pulse in the wrap cycle belongs to the new window.
    always_comb begin
        hold_last = (timer == HOLD_LAST);
        wait_last = (timer == WAIT_LAST);
        win_wrap  = (win_cnt == WIN_LAST);
        err_base  = win_wrap ? '0 : err_cnt;
        if (err_base == ERR_LIMIT) begin
            err_nxt = ERR_LIMIT;
        end else begin
            err_nxt = err_base + ERR_W'(rx_err);
        end
    end

    // Next-state selection: disable beats PLL loss, which beats normal progress.
    always_comb begin
        state_nxt = state;
        retry     = 1'b0;
        if (!lane_enable) begin
            state_nxt = IDLE;
        end else if (!pll_stable && (state > WAIT_PLL)) begin
            state_nxt = WAIT_PLL;
        end else begin
            case (state)
                IDLE:     state_nxt = WAIT_PLL;
                WAIT_PLL: if (pll_stable) state_nxt = TX_RST;
                TX_RST:   if (hold_last) state_nxt = TX_WAIT;
                TX_WAIT: begin
                    if (tx_reset_done) begin
                        state_nxt = RX_RST;
                    end else if (wait_last) begin
                        state_nxt = TX_RST;
                        retry     = 1'b1;
                    end
                end
                RX_RST:   if (hold_last) state_nxt = RX_WAIT;
                RX_WAIT: begin
                    if (rx_reset_done) begin
                        state_nxt = ALIGN;
                    end else if (wait_last) begin
                        state_nxt = RX_RST;
                        retry     = 1'b1;
                    end
                end
                ALIGN: begin
                    if (rx_aligned) begin
                        state_nxt = UP;
                    end else if (wait_last) begin
                        state_nxt = RX_RST;
                        retry     = 1'b1;
                    end
                end
                UP: begin
                    if (!rx_aligned || (err_nxt == ERR_LIMIT)) begin
                        state_nxt = RX_RST;
                        retry     = 1'b1;
                    end
                end
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // State register with registered Moore outputs, timers and retrain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tx_reset      <= 1'b1;
            rx_reset      <= 1'b1;
            lane_up       <= 1'b0;
            retrain_count <= '0;
            timer         <= '0;
            win_cnt       <= '0;
            err_cnt       <= '0;
        end else begin
            state    <= state_nxt;
            tx_reset <= tx_reset_of(state_nxt);
            rx_reset <= rx_reset_of(state_nxt);
            lane_up  <= (state_nxt == UP);

            if (state_nxt != state) begin
                timer <= '0;
            end else if (state inside {TX_RST, TX_WAIT, RX_RST, RX_WAIT, ALIGN}) begin
                timer <= timer + 1'b1;
            end

            if (retry && (retrain_count != RETRAIN_W'(RETRAIN_MAX))) begin
                retrain_count <= retrain_count + 1'b1;
            end

            if ((state == UP) && (state_nxt == UP)) begin
                win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
                err_cnt <= err_nxt;
            end else begin
                win_cnt <= '0;
                err_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gty_lane_bringup.sv
// Quad-level bring-up: shared QPLL lock qualifier feeding one independent
// sequencer per lane.
module gty_lane_bringup
    import gty_bringup_pkg::*;
#(
    parameter int NUM_LANES          = 3,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 64,
    parameter int DONE_TIMEOUT       = 65535,
    parameter int ERR_WINDOW         = 4096,
    parameter int ERR_THRESHOLD      = 16
) (
    input  logic              clk,
    input  logic              rst,
    gty_lane_bringup_if.slave gt
);
    localparam int               LOCK_W    = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_STABLE_CYCLES);

    logic [LOCK_W-1:0]      lock_cnt;
    logic                   pll_stable;
    logic [NUM_LANES-1:0]   tx_reset_v;
    logic [NUM_LANES-1:0]   rx_reset_v;
    logic [NUM_LANES-1:0]   lane_up_v;
    logic [8*NUM_LANES-1:0] retrain_v;
    logic [3*NUM_LANES-1:0] state_v;

    // Lock qualifier: count consecutive lock-high cycles, any drop restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt   <= '0;
            pll_stable <= 1'b0;
        end else begin
            if (!gt.qpll_lock) begin
                lock_cnt <= '0;
            end else if (lock_cnt != LOCK_FULL) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
            pll_stable <= (lock_cnt == LOCK_FULL);
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_bringup_state_t lane_st;

        gty_lane_bringup_fsm #(
            .RESET_HOLD_CYCLES (RESET_HOLD_CYCLES),
            .DONE_TIMEOUT      (DONE_TIMEOUT),
            .ERR_WINDOW        (ERR_WINDOW),
            .ERR_THRESHOLD     (ERR_THRESHOLD)
        ) u_fsm (
            .clk           (clk),
            .rst           (rst),
            .pll_stable    (pll_stable),
            .lane_enable   (gt.lane_enable[i]),
            .tx_reset_done (gt.tx_reset_done[i]),
            .rx_reset_done (gt.rx_reset_done[i]),
            .rx_aligned    (gt.rx_aligned[i]),
            .rx_err        (gt.rx_err[i]),
            .tx_reset      (tx_reset_v[i]),
            .rx_reset      (rx_reset_v[i]),
            .lane_up       (lane_up_v[i]),
            .retrain_count (retrain_v[8*i +: 8]),
            .state         (lane_st)
        );

        assign state_v[3*i +: 3] = lane_st;
    end

    assign gt.tx_reset      = tx_reset_v;
    assign gt.rx_reset      = rx_reset_v;
    assign gt.lane_up       = lane_up_v;
    assign gt.retrain_count = retrain_v;
    assign gt.lane_state    = state_v;

endmodule

// File: tb/tb_gty_lane_bringup.sv
// Bench for gty_lane_bringup: directed scenarios with hand-derived expectations
// plus randomized stimulus checked every cycle against a behavioural model.
module tb_gty_lane_bringup;
    localparam int NL   = 3;
    localparam int LOCK = 8;
    localparam int HOLD = 4;
    localparam int TO   = 20;
    localparam int WIN  = 32;
    localparam int THR  = 3;
    localparam int WW   = 3 * NL + 8 * NL + 3 * NL;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    initial forever #5 clk = ~clk;

    gty_lane_bringup_if #(.NUM_LANES(NL)) gt_if ();

    gty_lane_bringup #(
        .NUM_LANES          (NL),
        .LOCK_STABLE_CYCLES (LOCK),
        .RESET_HOLD_CYCLES  (HOLD),
        .DONE_TIMEOUT       (TO),
        .ERR_WINDOW         (WIN),
        .ERR_THRESHOLD      (THR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .gt  (gt_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [WW-1:0] exp_q[$];

    // ---------------- behavioural reference model ----------------
    int m_state[NL];
    int m_age[NL];
    int m_wid[NL];
    int m_errs[NL];
    int m_retr[NL];
    int lock_run;
    bit m_stable;

    task automatic model_reset();
        lock_run = 0;
        m_stable = 1'b0;
        for (int l = 0; l < NL; l++) begin
            m_state[l] = 0; m_age[l] = 0; m_wid[l] = 0; m_errs[l] = 0; m_retr[l] = 0;
        end
    endtask

    task automatic model_step();
        bit stable_seen;
        int s, ns, spent, wid;
        bit retry;
        if (rst) begin
            model_reset();
            return;
        end
        stable_seen = m_stable;
        m_stable    = (lock_run == LOCK);
        lock_run    = gt_if.qpll_lock ? ((lock_run < LOCK) ? lock_run + 1 : LOCK) : 0;
        for (int l = 0; l < NL; l++) begin
            s = m_state[l]; ns = s; retry = 1'b0; spent = m_age[l] + 1;
            if (!gt_if.lane_enable[l]) ns = 0;
            else if (!stable_seen && s >= 2) ns = 1;
            else begin
                case (s)
                    0: ns = 1;
                    1: if (stable_seen) ns = 2;
                    2: if (spent >= HOLD) ns = 3;
                    3: if (gt_if.tx_reset_done[l]) ns = 4;
                       else if (spent >= TO) begin ns = 2; retry = 1'b1; end
                    4: if (spent >= HOLD) ns = 5;
                    5: if (gt_if.rx_reset_done[l]) ns = 6;
                       else if (spent >= TO) begin ns = 4; retry = 1'b1; end
                    6: if (gt_if.rx_aligned[l]) ns = 7;
                       else if (spent >= TO) begin ns = 4; retry = 1'b1; end
                    default: begin
                        wid = spent / WIN;
                        if (wid != m_wid[l]) begin m_wid[l] = wid; m_errs[l] = 0; end
                        if (gt_if.rx_err[l]) m_errs[l]++;
                        if (!gt_if.rx_aligned[l] || m_errs[l] >= THR) begin ns = 4; retry = 1'b1; end
                    end
                endcase
            end
            if (retry && m_retr[l] < 255) m_retr[l]++;
            if (ns != s) begin m_age[l] = 0; m_wid[l] = 0; m_errs[l] = 0; end
            else m_age[l]++;
            m_state[l] = ns;
        end
    endtask

    function automatic logic [WW-1:0] model_word();
        logic [NL-1:0]   tx, rx, up;
        logic [8*NL-1:0] rc;
        logic [3*NL-1:0] st;
        for (int l = 0; l < NL; l++) begin
            tx[l] = (m_state[l] <= 2);
            rx[l] = (m_state[l] <= 4);
            up[l] = (m_state[l] == 7);
            rc[8*l +: 8] = 8'(m_retr[l]);
            st[3*l +: 3] = 3'(m_state[l]);
        end
        return {tx, rx, up, rc, st};
    endfunction

    function automatic logic [WW-1:0] dut_word();
        return {gt_if.tx_reset, gt_if.rx_reset, gt_if.lane_up, gt_if.retrain_count, gt_if.lane_state};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_lanes(input string name, input logic [2:0] st, input logic tx,
                               input logic rx, input logic up);
        check({name, "_state"}, gt_if.lane_state, {NL{st}});
        check({name, "_tx"}, gt_if.tx_reset, {NL{tx}});
        check({name, "_rx"}, gt_if.rx_reset, {NL{rx}});
        check({name, "_up"}, gt_if.lane_up, {NL{up}});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        logic [WW-1:0] e;
        @(posedge clk);
        model_step();
        exp_q.push_back(model_word());
        cyc++;
        @(negedge clk);
        e = exp_q.pop_front();
        check("model", dut_word(), e);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_all_up(input int limit, output int n);
        n = 0;
        while (gt_if.lane_up != {NL{1'b1}} && n < limit) begin
            step();
            n++;
        end
        check("all_up_within_budget", gt_if.lane_up, {NL{1'b1}});
    endtask

    task automatic drive_all_high();
        gt_if.qpll_lock     = 1'b1;
        gt_if.lane_enable   = '1;
        gt_if.tx_reset_done = '1;
        gt_if.rx_reset_done = '1;
        gt_if.rx_aligned    = '1;
        gt_if.rx_err        = '0;
    endtask

    typedef struct {
        int         at;
        logic [2:0] st;
        logic       tx;
        logic       rx;
        logic       up;
    } happy_vec_t;

    happy_vec_t happy_tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        logic [NL-1:0] v;

        happy_tbl[0] = '{1,  3'd1, 1'b1, 1'b1, 1'b0};
        happy_tbl[1] = '{9,  3'd1, 1'b1, 1'b1, 1'b0};
        happy_tbl[2] = '{10, 3'd2, 1'b1, 1'b1, 1'b0};
        happy_tbl[3] = '{13, 3'd2, 1'b1, 1'b1, 1'b0};
        happy_tbl[4] = '{14, 3'd3, 1'b0, 1'b1, 1'b0};
        happy_tbl[5] = '{15, 3'd4, 1'b0, 1'b1, 1'b0};
        happy_tbl[6] = '{18, 3'd4, 1'b0, 1'b1, 1'b0};
        happy_tbl[7] = '{19, 3'd5, 1'b0, 1'b0, 1'b0};
        happy_tbl[8] = '{20, 3'd6, 1'b0, 1'b0, 1'b0};
        happy_tbl[9] = '{21, 3'd7, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        drive_all_high();
        model_reset();
        repeat (3) step();
        check_lanes("reset", 3'd0, 1'b1, 1'b1, 1'b0);
        check("reset_retrain", gt_if.retrain_count, 0);

        // Happy path, counted in edges after rst release.
        rst = 1'b0;
        cyc = 0;
        foreach (happy_tbl[i]) begin
            run_to(happy_tbl[i].at);
            check_lanes($sformatf("happy_e%0d", happy_tbl[i].at), happy_tbl[i].st,
                        happy_tbl[i].tx, happy_tbl[i].rx, happy_tbl[i].up);
        end
        check("happy_retrain", gt_if.retrain_count, 0);

        // Lock glitch while UP: qualifier drops one edge later, lanes the edge after.
        gt_if.qpll_lock = 1'b0;
        step();
        gt_if.qpll_lock = 1'b1;
        step();
        step();
        check_lanes("glitch", 3'd1, 1'b1, 1'b1, 1'b0);
        wait_all_up(60, n);
        check("glitch_requal_latency", n, 19);
        check("glitch_retrain", gt_if.retrain_count, 0);

        // TX timeout: restart bring-up with tx_reset_done held low.
        gt_if.tx_reset_done = '0;
        gt_if.qpll_lock = 1'b0;
        step();
        base = cyc;
        gt_if.qpll_lock = 1'b1;
        run_to(base + 14);
        check_lanes("txto_enter_wait", 3'd3, 1'b0, 1'b1, 1'b0);
        run_to(base + 33);
        check_lanes("txto_last_wait", 3'd3, 1'b0, 1'b1, 1'b0);
        run_to(base + 34);
        check_lanes("txto_retry1", 3'd2, 1'b1, 1'b1, 1'b0);
        check("txto_retrain1", gt_if.retrain_count, 24'h010101);
        run_to(base + 57);
        check_lanes("txto_last_wait2", 3'd3, 1'b0, 1'b1, 1'b0);
        run_to(base + 58);
        check_lanes("txto_retry2", 3'd2, 1'b1, 1'b1, 1'b0);
        check("txto_retrain2", gt_if.retrain_count, 24'h020202);
        run_to(base + 64);
        gt_if.tx_reset_done = '1;
        wait_all_up(60, n);
        check("txto_retrain_final", gt_if.retrain_count, 24'h020202);

        // Error burst on lane 1: third pulse in a window forces RX retrain.
        for (int k = 0; k < 5; k++) begin
            gt_if.rx_err = (k % 2 == 0) ? 3'b010 : 3'b000;
            step();
        end
        gt_if.rx_err = '0;
        check("burst_lane1_state", gt_if.lane_state[5:3], 3'd4);
        check("burst_lane_up", gt_if.lane_up, 3'b101);
        check("burst_retrain", gt_if.retrain_count, 24'h020302);
        wait_all_up(60, n);

        // Two pulses per window, including one in the wrap cycle: no retrain.
        for (int k = 0; k < 100; k++) begin
            gt_if.rx_err = (k inside {5, 30, 31, 50, 70, 80}) ? 3'b010 : 3'b000;
            step();
        end
        gt_if.rx_err = '0;
        check("window_lane_up", gt_if.lane_up, 3'b111);
        check("window_retrain", gt_if.retrain_count, 24'h020302);

        // Disable lane 2 while it waits in RX_WAIT.
        gt_if.rx_reset_done = 3'b011;
        gt_if.lane_enable   = 3'b011;
        step();
        base = cyc;
        check("dis_idle_state", gt_if.lane_state[8:6], 3'd0);
        gt_if.lane_enable = 3'b111;
        run_to(base + 11);
        check("dis_rxwait_state", gt_if.lane_state[8:6], 3'd5);
        run_to(base + 13);
        gt_if.lane_enable = 3'b011;
        step();
        check("dis_state", gt_if.lane_state[8:6], 3'd0);
        check("dis_resets", {gt_if.tx_reset[2], gt_if.rx_reset[2]}, 2'b11);
        check("dis_others_up", gt_if.lane_up, 3'b011);
        check("dis_retrain", gt_if.retrain_count, 24'h020302);
        gt_if.lane_enable   = '1;
        gt_if.rx_reset_done = '1;
        wait_all_up(60, n);

        // Saturation: keep lane 0 unaligned for 300+ ALIGN timeouts.
        gt_if.rx_aligned = 3'b110;
        repeat (300 * 25 + 30) step();
        check("sat_retrain_lane0", gt_if.retrain_count[7:0], 8'd255);
        check("sat_retrain_others", gt_if.retrain_count[23:8], 16'h0203);
        check("sat_others_up", gt_if.lane_up, 3'b110);
        gt_if.rx_aligned = '1;
        wait_all_up(60, n);

        // Randomized stimulus, checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 31) == 0) gt_if.qpll_lock = ($urandom_range(0, 3) != 0);
            v = gt_if.lane_enable;
            for (int l = 0; l < NL; l++) if ($urandom_range(0, 63) == 0) v[l] = ($urandom_range(0, 3) != 0);
            gt_if.lane_enable = v;
            v = gt_if.tx_reset_done;
            for (int l = 0; l < NL; l++) if ($urandom_range(0, 15) == 0) v[l] = ($urandom_range(0, 2) != 0);
            gt_if.tx_reset_done = v;
            v = gt_if.rx_reset_done;
            for (int l = 0; l < NL; l++) if ($urandom_range(0, 15) == 0) v[l] = ($urandom_range(0, 2) != 0);
            gt_if.rx_reset_done = v;
            v = gt_if.rx_aligned;
            for (int l = 0; l < NL; l++) if ($urandom_range(0, 15) == 0) v[l] = ($urandom_range(0, 3) != 0);
            gt_if.rx_aligned = v;
            for (int l = 0; l < NL; l++) v[l] = ($urandom_range(0, 9) == 0);
            gt_if.rx_err = v;
            step();
        end

        // Reset mid-operation, then a second full bring-up.
        drive_all_high();
        rst = 1'b1;
        step();
        check_lanes("midrst", 3'd0, 1'b1, 1'b1, 1'b0);
        check("midrst_retrain", gt_if.retrain_count, 0);
        rst = 1'b0;
        wait_all_up(60, n);
        check("rebring_latency", n, 21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
